// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions used by the transmit serializer and
//               the receiver: word-length encoding, transmitter state enum
//               and the parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // WLS field encoding (line control register)
    localparam logic [1:0] c_WLS_5 = 2'b00;
    localparam logic [1:0] c_WLS_6 = 2'b01;
    localparam logic [1:0] c_WLS_7 = 2'b10;
    localparam logic [1:0] c_WLS_8 = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Parity bit for one character. Bits above the word length do not
    // contribute. With parity disabled the idle (mark) level is returned.
    function automatic logic calc_parity(
        input logic [7:0] data,
        input logic [1:0] wls,
        input logic       pen,
        input logic       eps,
        input logic       sp
    );
        logic [7:0] mask;
        logic       x;
        case (wls)
            c_WLS_5: mask = 8'h1F;
            c_WLS_6: mask = 8'h3F;
            c_WLS_7: mask = 8'h7F;
            c_WLS_8: mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        x = ^(data & mask);
        if (!pen) begin
            return 1'b1;
        end
        if (sp) begin
            return ~eps;
        end
        return eps ? x : ~x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit serializer. Sends start, 5..8 data bits (LSB
//               first), optional parity and 1/1.5/2 stop bits, timed by an
//               oversampling clock-enable strobe.
// Ports       : CLK, RSTN (async, active-low)
//               CE          - oversample strobe (OVERSAMPLE per bit)
//               START, DIN  - character request (accepted when BUSY=0)
//               WLS, STB, PEN, EPS, SP - frame format, latched on accept
//               BC          - live break control, forces SOUT low
//               SOUT        - serial line, idle high
//               BUSY        - character in flight
//               TXFINISHED  - one-cycle pulse after the last stop strobe
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       CE,
    input  logic       START,
    input  logic [7:0] DIN,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    output logic       SOUT,
    output logic       BUSY,
    output logic       TXFINISHED
);
    import uart_pkg::*;

    localparam int              c_CW            = $clog2(OVERSAMPLE);
    localparam logic [c_CW-1:0] c_SUB_LAST      = c_CW'(OVERSAMPLE - 1);
    localparam logic [c_CW-1:0] c_SUB_HALF_LAST = c_CW'(OVERSAMPLE / 2 - 1);

    tx_state_t       r_state;
    logic [c_CW-1:0] r_sub;
    logic [2:0]      r_idx;
    logic [7:0]      r_din;
    logic [1:0]      r_wls;
    logic            r_stb;
    logic            r_pen;
    logic            r_par;     // parity resolved once at accept time
    logic            r_stop2;   // currently in the second stop period
    logic            r_line;
    logic            r_busy;
    logic            r_done;

    logic [2:0]      w_last_idx;
    logic [c_CW-1:0] w_stop_last;
    logic            w_bit_end;

    // Index of the final data bit: 4..7 for 5..8 bit words
    assign w_last_idx  = 3'd4 + {1'b0, r_wls};
    // The 1.5-stop case ends the second stop period at half a bit
    assign w_stop_last = (r_stop2 && (r_wls == c_WLS_5)) ? c_SUB_HALF_LAST : c_SUB_LAST;
    assign w_bit_end   = CE && (r_sub == c_SUB_LAST);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= TX_IDLE;
            r_sub   <= '0;
            r_idx   <= '0;
            r_din   <= '0;
            r_wls   <= '0;
            r_stb   <= 1'b0;
            r_pen   <= 1'b0;
            r_par   <= 1'b0;
            r_stop2 <= 1'b0;
            r_line  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (START) begin
                        r_din   <= DIN;
                        r_wls   <= WLS;
                        r_stb   <= STB;
                        r_pen   <= PEN;
                        r_par   <= calc_parity(DIN, WLS, PEN, EPS, SP);
                        r_sub   <= '0;
                        r_idx   <= '0;
                        r_stop2 <= 1'b0;
                        r_line  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_sub   <= '0;
                        r_line  <= r_din[0];
                        r_state <= TX_DATA;
                    end else if (CE) begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_sub <= '0;
                        if (r_idx == w_last_idx) begin
                            if (r_pen) begin
                                r_line  <= r_par;
                                r_state <= TX_PARITY;
                            end else begin
                                r_line  <= 1'b1;
                                r_state <= TX_STOP;
                            end
                        end else begin
                            r_idx  <= r_idx + 3'd1;
                            r_line <= r_din[r_idx + 3'd1];
                        end
                    end else if (CE) begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (w_bit_end) begin
                        r_sub   <= '0;
                        r_line  <= 1'b1;
                        r_state <= TX_STOP;
                    end else if (CE) begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (CE && (r_sub == w_stop_last)) begin
                        r_sub <= '0;
                        if (r_stb && !r_stop2) begin
                            r_stop2 <= 1'b1;
                        end else begin
                            r_stop2 <= 1'b0;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= TX_IDLE;
                        end
                    end else if (CE) begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Break is applied live on top of the registered line level
    assign SOUT       = r_line & ~BC;
    assign BUSY       = r_busy;
    assign TXFINISHED = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench for uart_tx_serializer. A frame-level
//               model (strobe count into the frame -> line level) is compared
//               to the DUT every cycle; directed frames pin the model with
//               hand-computed levels and frame lengths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       CE = 1'b0;
    logic       START = 1'b0;
    logic [7:0] DIN = '0;
    logic [1:0] WLS = '0;
    logic       STB = 1'b0;
    logic       PEN = 1'b0;
    logic       EPS = 1'b0;
    logic       SP = 1'b0;
    logic       BC = 1'b0;
    logic       SOUT;
    logic       BUSY;
    logic       TXFINISHED;

    int total = 0;
    int bad   = 0;

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .CE         (CE),
        .START      (START),
        .DIN        (DIN),
        .WLS        (WLS),
        .STB        (STB),
        .PEN        (PEN),
        .EPS        (EPS),
        .SP         (SP),
        .BC         (BC),
        .SOUT       (SOUT),
        .BUSY       (BUSY),
        .TXFINISHED (TXFINISHED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame model: a frame is a list of bit levels, each OS strobes long
    // (the last stop region may be 1, 1.5 or 2 bits); the line level is
    // looked up from the number of strobes counted since acceptance.
    // ------------------------------------------------------------------
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_pen  = 1'b0;
    logic       m_par  = 1'b0;
    logic [7:0] m_din  = '0;
    int         m_wl   = 5;
    int         m_cnt  = 0;
    int         m_total = 0;

    function automatic logic level_at(input int k);
        int b;
        if (k < OS) return 1'b0;
        b = k / OS - 1;
        if (b < m_wl) return m_din[b];
        if (m_pen && b == m_wl) return m_par;
        return 1'b1;
    endfunction

    always @(posedge CLK or negedge RSTN) begin : model
        int ones;
        int stop;
        if (!RSTN) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (CE) begin
                    m_cnt++;
                    if (m_cnt == m_total) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (START) begin
                m_din = DIN;
                m_wl  = 5 + int'(WLS);
                m_pen = PEN;
                ones  = 0;
                for (int i = 0; i < m_wl; i++) ones += int'(DIN[i]);
                m_par   = SP ? ~EPS : (EPS ? (ones % 2 == 1) : (ones % 2 == 0));
                stop    = !STB ? OS : ((WLS == 2'b00) ? (OS * 3) / 2 : 2 * OS);
                m_total = OS * (1 + m_wl + (PEN ? 1 : 0)) + stop;
                m_cnt   = 0;
                m_busy  = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin : compare
        logic e;
        e = (m_busy ? level_at(m_cnt) : 1'b1) & ~BC;
        check("sout_vs_model", SOUT, e);
        check("busy_vs_model", BUSY, m_busy);
        check("txfinished_vs_model", TXFINISHED, m_done);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 ns after the rising edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_cfg(input logic [7:0] din, input logic [1:0] wls, input logic stb,
                           input logic pen, input logic eps, input logic sp);
        DIN = din; WLS = wls; STB = stb; PEN = pen; EPS = eps; SP = sp;
    endtask

    task automatic send();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Full frame with CE held high; checks one level mid-frame and the
    // number of cycles from acceptance to TXFINISHED.
    task automatic run_frame(input string tag, input int exp_len, input int probe_at,
                             input logic probe_exp);
        int n;
        send();
        check({tag, "_accept_sout"}, SOUT, 1'b0);
        check({tag, "_accept_busy"}, BUSY, 1'b1);
        n = 0;
        while (!TXFINISHED && n < 1000) begin
            tick();
            n++;
            if (n == probe_at) check({tag, "_probe"}, SOUT, probe_exp);
        end
        check_int({tag, "_frame_len"}, n, exp_len);
        check({tag, "_done_busy"}, BUSY, 1'b0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [9:0] pat;
        int n;

        // Reset state
        RSTN = 1'b0;
        repeat (3) tick();
        check("reset_sout", SOUT, 1'b1);
        check("reset_busy", BUSY, 1'b0);
        check("reset_txfinished", TXFINISHED, 1'b0);
        RSTN = 1'b1;
        tick();
        CE = 1'b1;

        // 8N1 0x55: levels 0,1,0,1,0,1,0,1,0,1 at 16 cycles each, done at 160
        set_cfg(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        pat = 10'b1010101010;
        send();
        for (int k = 0; k < 10; k++) begin
            repeat (8) tick();
            check("8n1_bit_level", SOUT, pat[k]);
            check("8n1_busy", BUSY, 1'b1);
            repeat (8) tick();
        end
        check("8n1_txfinished_at_160", TXFINISHED, 1'b1);
        check("8n1_busy_low_at_done", BUSY, 1'b0);

        // 7E2 0x03: parity 0 in strobes 128..143, 176 strobes total
        set_cfg(8'h03, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        run_frame("7e2", 176, 136, 1'b0);

        // 5-bit stick parity, 1.5 stop: parity 1 at 96..111, 112+24 = 136
        set_cfg(8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        run_frame("stick15", 136, 104, 1'b1);

        // Back-to-back: START in the TXFINISHED cycle, then ignored START mid-frame
        set_cfg(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        send();
        check("b2b_start_bit", SOUT, 1'b0);
        check("b2b_busy", BUSY, 1'b1);
        for (n = 1; n <= 160; n++) begin
            tick();
            if (n == 20) begin
                set_cfg(8'hF0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
                START = 1'b1;
            end
            if (n == 21) START = 1'b0;
            if (n == 88) check("ignored_start_bit4", SOUT, 1'b0);
            if (n == 72) check("ignored_start_bit3", SOUT, 1'b1);
        end
        check("ignored_start_len", TXFINISHED, 1'b1);

        // Break mid-data on an all-ones character
        set_cfg(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        send();
        for (n = 1; n <= 160; n++) begin
            tick();
            if (n == 40) begin
                BC = 1'b1;
                #1;
                check("break_immediate", SOUT, 1'b0);
            end
        end
        check("break_txfinished", TXFINISHED, 1'b1);
        tick();
        BC = 1'b0;
        #1;
        check("break_release_idle", SOUT, 1'b1);

        // Reset during data bits of a 0x00 character
        tick();
        set_cfg(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        send();
        repeat (50) tick();
        RSTN = 1'b0;
        #1;
        check("rst_async_sout", SOUT, 1'b1);
        check("rst_async_busy", BUSY, 1'b0);
        check("rst_async_txfinished", TXFINISHED, 1'b0);
        repeat (3) tick();
        RSTN = 1'b1;
        repeat (40) tick();
        check("rst_idle_sout", SOUT, 1'b1);
        check("rst_idle_busy", BUSY, 1'b0);

        // Randomized traffic: CE density, config and BC vary; the model
        // compare runs every cycle.
        for (int c = 0; c < 16000; c++) begin
            CE    = ((c / 2000) % 2 == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
            START = ($urandom_range(0, 15) == 0) || (TXFINISHED && ($urandom_range(0, 1) == 1));
            DIN   = 8'($urandom);
            WLS   = 2'($urandom);
            STB   = 1'($urandom);
            PEN   = 1'($urandom);
            EPS   = 1'($urandom);
            SP    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) BC = ~BC;
            tick();
        end

        START = 1'b0;
        BC    = 1'b0;
        CE    = 1'b1;
        n = 0;
        while (BUSY && n < 1000) begin
            tick();
            n++;
        end
        check("final_idle", BUSY, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
